// File: rtl/dma_host_model.sv
// Host/memory end of a DMA link: cache-line RAM, FWFT read FIFO, buffered write FIFO, backdoor port.
// Optional DMA_HOST_MODEL_STALL_EN adds LFSR-driven stalls on read issue and write drain.
module dma_host_model #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 64,
  parameter int SIZE_WIDTH      = 43,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [SIZE_WIDTH-1:0]     rd_size,
  input  logic                      rd_go,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      empty,
  output logic                      rd_done,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [SIZE_WIDTH-1:0]     wr_size,
  input  logic                      wr_go,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      full,
  output logic                      wr_done,
  input  logic                      bd_we,
  input  logic                      bd_re,
  input  logic [MEM_DEPTH_LOG2-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0]     bd_wdata,
  output logic [DATA_WIDTH-1:0]     bd_rdata
);

  localparam int MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL_LVL = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);
  localparam logic [SIZE_WIDTH-1:0]    SIZE_ONE      = SIZE_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

  state_t                     r_rd_state, r_wr_state;
  logic [MEM_DEPTH_LOG2-1:0]  r_rd_base, r_wr_base;
  logic [SIZE_WIDTH-1:0]      r_rd_size, r_rd_issued, r_rd_popped;
  logic [SIZE_WIDTH-1:0]      r_wr_size, r_wr_pushed, r_wr_committed;
  logic                       r_rd_done, r_wr_done, r_rd_rvalid;
  logic [DATA_WIDTH-1:0]      r_rd_q, r_bd_rdata;
  logic [DATA_WIDTH-1:0]      r_mem    [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]      r_rf_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      r_wf_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_rf_wp, r_rf_rp, r_wf_wp, r_wf_rp;
  logic [FIFO_DEPTH_LOG2:0]   r_rf_count, r_wf_count;

  logic                       w_rd_stall, w_wr_stall;
  logic [MEM_DEPTH_LOG2-1:0]  w_rd_idx, w_wr_idx, w_mem_waddr, w_mem_raddr;
  logic [FIFO_DEPTH_LOG2:0]   w_rf_level;
  logic                       w_rd_issue, w_rf_pop, w_full, w_wf_push, w_wr_drain, w_mem_we;
  logic [DATA_WIDTH-1:0]      w_mem_wdata, w_mem_rdata;
  logic                       w_unused_addr;

`ifdef DMA_HOST_MODEL_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_rd_stall = r_lfsr[0];
  assign w_wr_stall = r_lfsr[1];
`else
  assign w_rd_stall = 1'b0;
  assign w_wr_stall = 1'b0;
`endif

  // Line index wraps modulo the RAM depth; byte offset within a line is ignored.
  assign w_rd_idx   = r_rd_base + r_rd_issued[MEM_DEPTH_LOG2-1:0];
  assign w_wr_idx   = r_wr_base + r_wr_committed[MEM_DEPTH_LOG2-1:0];
  assign w_rf_level = r_rf_count + (FIFO_DEPTH_LOG2+1)'(r_rd_rvalid);

  assign w_rd_issue = !rst && (r_rd_state == ST_ACTIVE) && !rd_go && !bd_re && !w_rd_stall &&
                      (r_rd_issued != r_rd_size) && (w_rf_level < FIFO_FULL_LVL);
  assign w_rf_pop   = rd_en && (r_rf_count != '0);

  assign w_full     = (r_wr_state != ST_ACTIVE) || (r_wf_count == FIFO_FULL_LVL) ||
                      (r_wr_pushed == r_wr_size);
  assign w_wf_push  = wr_en && !w_full && !wr_go;
  assign w_wr_drain = !rst && (r_wr_state == ST_ACTIVE) && !wr_go && (r_wf_count != '0) &&
                      !bd_we && !w_wr_stall;

  // Backdoor traffic owns each RAM port in the cycle it is requested.
  assign w_mem_we    = bd_we || w_wr_drain;
  assign w_mem_waddr = bd_we ? bd_addr : w_wr_idx;
  assign w_mem_wdata = bd_we ? bd_wdata : r_wf_mem[r_wf_rp];
  assign w_mem_raddr = bd_re ? bd_addr : w_rd_idx;
  assign w_mem_rdata = r_mem[w_mem_raddr];

  assign w_unused_addr = ^{rd_addr[5:0], rd_addr[ADDR_WIDTH-1:6+MEM_DEPTH_LOG2],
                           wr_addr[5:0], wr_addr[ADDR_WIDTH-1:6+MEM_DEPTH_LOG2]};

  // NOTE: RAM and FIFO storage have no reset; only pointers/flags are reset, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (w_mem_we)   r_mem[w_mem_waddr] <= w_mem_wdata;
    if (w_rd_issue) r_rd_q <= w_mem_rdata;
    if (r_rd_rvalid) r_rf_mem[r_rf_wp] <= r_rd_q;
    if (w_wf_push)   r_wf_mem[r_wf_wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        r_bd_rdata <= '0;
    else if (bd_re) r_bd_rdata <= w_mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state  <= ST_IDLE;
      r_rd_base   <= '0;
      r_rd_size   <= '0;
      r_rd_issued <= '0;
      r_rd_popped <= '0;
      r_rd_done   <= 1'b0;
      r_rd_rvalid <= 1'b0;
      r_rf_wp     <= '0;
      r_rf_rp     <= '0;
      r_rf_count  <= '0;
    end else if (rd_go) begin
      r_rd_state  <= (rd_size == '0) ? ST_DONE : ST_ACTIVE;
      r_rd_base   <= rd_addr[6 +: MEM_DEPTH_LOG2];
      r_rd_size   <= rd_size;
      r_rd_issued <= '0;
      r_rd_popped <= '0;
      r_rd_done   <= (rd_size == '0);
      r_rd_rvalid <= 1'b0;
      r_rf_wp     <= '0;
      r_rf_rp     <= '0;
      r_rf_count  <= '0;
    end else begin
      r_rd_rvalid <= w_rd_issue;
      r_rf_count  <= w_rf_level - (FIFO_DEPTH_LOG2+1)'(w_rf_pop);
      if (w_rd_issue)  r_rd_issued <= r_rd_issued + SIZE_ONE;
      if (r_rd_rvalid) r_rf_wp <= r_rf_wp + 1'b1;
      if (w_rf_pop) begin
        r_rf_rp     <= r_rf_rp + 1'b1;
        r_rd_popped <= r_rd_popped + SIZE_ONE;
        if (r_rd_popped + SIZE_ONE == r_rd_size) begin
          r_rd_state <= ST_DONE;
          r_rd_done  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state     <= ST_IDLE;
      r_wr_base      <= '0;
      r_wr_size      <= '0;
      r_wr_pushed    <= '0;
      r_wr_committed <= '0;
      r_wr_done      <= 1'b0;
      r_wf_wp        <= '0;
      r_wf_rp        <= '0;
      r_wf_count     <= '0;
    end else if (wr_go) begin
      // A restart drops whatever is still buffered from the previous transfer.
      r_wr_state     <= (wr_size == '0) ? ST_DONE : ST_ACTIVE;
      r_wr_base      <= wr_addr[6 +: MEM_DEPTH_LOG2];
      r_wr_size      <= wr_size;
      r_wr_pushed    <= '0;
      r_wr_committed <= '0;
      r_wr_done      <= (wr_size == '0);
      r_wf_wp        <= '0;
      r_wf_rp        <= '0;
      r_wf_count     <= '0;
    end else begin
      r_wf_count <= r_wf_count + (FIFO_DEPTH_LOG2+1)'(w_wf_push) - (FIFO_DEPTH_LOG2+1)'(w_wr_drain);
      if (w_wf_push) begin
        r_wf_wp     <= r_wf_wp + 1'b1;
        r_wr_pushed <= r_wr_pushed + SIZE_ONE;
      end
      if (w_wr_drain) begin
        r_wf_rp        <= r_wf_rp + 1'b1;
        r_wr_committed <= r_wr_committed + SIZE_ONE;
        if (r_wr_committed + SIZE_ONE == r_wr_size) begin
          r_wr_state <= ST_DONE;
          r_wr_done  <= 1'b1;
        end
      end
    end
  end

  assign empty    = (r_rf_count == '0);
  assign rd_data  = empty ? '0 : r_rf_mem[r_rf_rp];
  assign rd_done  = r_rd_done;
  assign full     = w_full;
  assign wr_done  = r_wr_done;
  assign bd_rdata = r_bd_rdata;

endmodule

// File: tb/tb_dma_host_model.sv
// Self-checking bench for dma_host_model: random line data checked against an array model of host memory.
module tb_dma_host_model;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int SW = 43;
  localparam int ML = 10;
  localparam int MD = 1 << ML;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [SW-1:0] rd_size, wr_size;
  logic          rd_go, rd_en, empty, rd_done;
  logic          wr_go, wr_en, full, wr_done;
  logic [DW-1:0] rd_data, wr_data, bd_wdata, bd_rdata;
  logic          bd_we, bd_re;
  logic [ML-1:0] bd_addr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model_mem [MD];

  dma_host_model dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_go(rd_go), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
    .wr_addr(wr_addr), .wr_size(wr_size), .wr_go(wr_go), .wr_en(wr_en),
    .wr_data(wr_data), .full(full), .wr_done(wr_done),
    .bd_we(bd_we), .bd_re(bd_re), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input longint unsigned addr);
    return int'((addr / 64) % MD);
  endfunction

  task automatic bd_write(input int idx, input logic [DW-1:0] data);
    bd_we = 1'b1; bd_addr = ML'(idx); bd_wdata = data;
    tick();
    bd_we = 1'b0;
    model_mem[idx] = data;
  endtask

  task automatic bd_check(input int idx, input string tag);
    bd_re = 1'b1; bd_addr = ML'(idx);
    tick();
    bd_re = 1'b0;
    check(tag, bd_rdata, model_mem[idx]);
  endtask

  task automatic rd_start(input longint unsigned addr, input int size);
    rd_addr = addr; rd_size = SW'(size); rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
  endtask

  // Pops n_pop lines and compares each with the model line at (base + k) mod depth.
  task automatic rd_drain(input int base, input int size, input int n_pop, input int hold,
                          input bit rand_en, input bit bd_mode, input string tag);
    int got = 0;
    int cyc = 0;
    bit bd_pend = 0;
    int bd_a = 0;
    while (got < n_pop && cyc < 4000) begin
      if (bd_pend) check({tag, "_bd"}, bd_rdata, model_mem[bd_a]);
      if (hold > 0 && cyc == hold) check({tag, "_held"}, DW'(empty), DW'(0));
      rd_en = (cyc < hold) ? 1'b0 : (rand_en ? ($urandom_range(0, 2) != 0) : 1'b1);
      bd_pend = 0;
      bd_re   = 1'b0;
      if (bd_mode && $urandom_range(0, 2) == 0) begin
        bd_a = int'($urandom_range(0, 63));
        bd_re = 1'b1; bd_addr = ML'(bd_a); bd_pend = 1;
      end
      if (rd_en && !empty) begin
        check({tag, "_data"}, rd_data, model_mem[(base + got) % MD]);
        if (got == size - 1) check({tag, "_notdone"}, DW'(rd_done), DW'(0));
        got++;
      end
      tick();
      cyc++;
    end
    rd_en = 1'b0;
    bd_re = 1'b0;
    if (bd_pend) check({tag, "_bd"}, bd_rdata, model_mem[bd_a]);
    check({tag, "_count"}, DW'(got), DW'(n_pop));
    if (n_pop == size) begin
      check({tag, "_done"}, DW'(rd_done), DW'(1));
      check({tag, "_empty"}, DW'(empty), DW'(1));
    end
  endtask

  task automatic wr_run(input longint unsigned addr, input int size, input bit rand_en,
                        input bit bd_mode, input string tag);
    logic [DW-1:0] q [$];
    int base = line_of(addr);
    int cyc = 0;
    int a;
    wr_addr = addr; wr_size = SW'(size); wr_go = 1'b1;
    tick();
    wr_go = 1'b0;
    if (size > 0) check({tag, "_open"}, DW'(full), DW'(0));
    while (q.size() < size && cyc < 4000) begin
      wr_en   = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_data = rand_line();
      bd_we   = 1'b0;
      if (bd_mode && $urandom_range(0, 2) == 0) begin
        a = 512 + int'($urandom_range(0, 15));
        bd_we = 1'b1; bd_addr = ML'(a); bd_wdata = rand_line();
        model_mem[a] = bd_wdata;
      end
      if (wr_en && !full) q.push_back(wr_data);
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    bd_we = 1'b0;
    check({tag, "_pushed"}, DW'(q.size()), DW'(size));
    check({tag, "_full"}, DW'(full), DW'(1));
    // One extra push beyond the size must be dropped.
    wr_en = 1'b1; wr_data = rand_line();
    tick();
    wr_en = 1'b0;
    cyc = 0;
    while (!wr_done && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, DW'(wr_done), DW'(1));
    check({tag, "_fulldone"}, DW'(full), DW'(1));
    for (int k = 0; k < size; k++) model_mem[(base + k) % MD] = q[k];
  endtask

  initial begin
    int b, s;
    longint unsigned ad;
    rst = 1'b1;
    rd_addr = '0; rd_size = '0; rd_go = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_size = '0; wr_go = 1'b0; wr_en = 1'b0; wr_data = '0;
    bd_we = 1'b0; bd_re = 1'b0; bd_addr = '0; bd_wdata = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_empty",   DW'(empty),   DW'(1));
    check("rst_full",    DW'(full),    DW'(1));
    check("rst_rd_done", DW'(rd_done), DW'(0));
    check("rst_wr_done", DW'(wr_done), DW'(0));
    check("rst_rd_data", rd_data,      '0);
    check("rst_bd_rdata", bd_rdata,    '0);

    for (int i = 0; i < 16; i++) bd_write(i, DW'(i * 3));
    for (int i = 16; i < 64; i++) bd_write(i, rand_line());
    for (int i = 256; i < 265; i++) bd_write(i, rand_line());
    for (int i = 512; i < 528; i++) bd_write(i, rand_line());
    bd_write(1023, rand_line());

    // Sequential read of 16 lines with rd_en held high, including first-line latency.
    rd_en = 1'b1;
    rd_start(64'h0, 16);
`ifndef DMA_HOST_MODEL_STALL_EN
    check("lat_c1", DW'(empty), DW'(1));
    tick();
    check("lat_c2", DW'(empty), DW'(1));
    tick();
    check("lat_c3", DW'(empty), DW'(0));
    check("lat_data", rd_data, DW'(0));
`endif
    rd_drain(0, 16, 16, 0, 1'b0, 1'b0, "seq");

    wr_run(64'h4000, 8, 1'b0, 1'b0, "wr");
    for (int i = 256; i < 265; i++) bd_check(i, "wr_readback");

    rd_start(64'hFFC0, 3);
    rd_drain(1023, 3, 3, 0, 1'b1, 1'b0, "wrap");

    rd_start(64'h0, 20);
    rd_drain(0, 20, 20, 30, 1'b0, 1'b0, "hold");

    rd_start(64'h1234, 0);
    check("rd0_done", DW'(rd_done), DW'(1));
    check("rd0_empty", DW'(empty), DW'(1));
    tick();
    check("rd0_empty2", DW'(empty), DW'(1));
    wr_addr = 64'h8000; wr_size = '0; wr_go = 1'b1;
    tick();
    wr_go = 1'b0;
    check("wr0_done", DW'(wr_done), DW'(1));
    check("wr0_full", DW'(full), DW'(1));

    for (int t = 0; t < 4; t++) begin
      b = int'($urandom_range(0, 40));
      s = int'($urandom_range(1, 12));
      ad = longint'(b) * 64 + longint'($urandom_range(0, 63));
      rd_start(ad, s);
      rd_drain(b, s, s, 0, 1'b1, 1'b1, "rnd_rd");
    end

    for (int t = 0; t < 3; t++) begin
      b = 600 + int'($urandom_range(0, 100));
      s = int'($urandom_range(1, 12));
      ad = longint'(b) * 64 + longint'($urandom_range(0, 63));
      wr_run(ad, s, 1'b1, 1'b1, "rnd_wr");
      bd_check(b, "rnd_wr_bd");
      bd_check(512 + int'($urandom_range(0, 15)), "scratch_bd");
      rd_start(ad, s);
      rd_drain(b, s, s, 0, 1'b1, 1'b0, "rnd_wr_rd");
    end

    // Reset in the middle of a 16-line read, then a clean rerun.
    rd_start(64'h0, 16);
    rd_drain(0, 16, 5, 0, 1'b0, 1'b0, "prerst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_empty", DW'(empty), DW'(1));
    check("midrst_done", DW'(rd_done), DW'(0));
    check("midrst_data", rd_data, '0);
    rd_start(64'h0, 16);
    rd_drain(0, 16, 16, 0, 1'b0, 1'b0, "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
